// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM half-port among NREQ requesters,
// with optional post-reset zero clear and a tagged read-return pipeline.
module bram_port_arbiter #(
    parameter int NREQ           = 4,
    parameter int ABITS          = 14,
    parameter int DBITS          = 18,
    parameter int BE_W           = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     CLK_i,
    input  logic                     RESET_N_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*ABITS-1:0]    addr_i,
    input  logic [NREQ*DBITS-1:0]    wdata_i,
    input  logic [NREQ*BE_W-1:0]     be_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic                     rvalid_o,
    output logic [$clog2(NREQ)-1:0]  rid_o,
    output logic [DBITS-1:0]         rdata_o,
    output logic                     busy_o,
    output logic [ABITS-1:0]         ram_addr_o,
    output logic                     ram_ren_o,
    output logic                     ram_wen_o,
    output logic [BE_W-1:0]          ram_be_o,
    output logic [DBITS-1:0]         ram_wdata_o,
    input  logic [DBITS-1:0]         ram_rdata_i
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] clr_addr_q, clr_addr_d;
    logic [IW-1:0]    last_q, last_d;

    logic [ABITS-1:0] ram_addr_q, ram_addr_d;
    logic [DBITS-1:0] ram_wdata_q, ram_wdata_d;
    logic [BE_W-1:0]  ram_be_q, ram_be_d;
    logic             ram_ren_q, ram_ren_d;
    logic             ram_wen_q, ram_wen_d;

    logic             rd1_vld_q, rd1_vld_d;
    logic [IW-1:0]    rd1_id_q, rd1_id_d;
    logic             rd2_vld_q, rd2_vld_d;
    logic [IW-1:0]    rd2_id_q, rd2_id_d;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    cand;
    logic             gnt_any;

    // Scan from last_q+1 upward; the first active request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        gnt_any = 1'b0;
        if (RESET_N_i && state_q == S_RUN) begin
            for (int i = 1; i <= NREQ; i++) begin
                cand = IW'((int'(last_q) + i) % NREQ);
                if (!gnt_any && req_i[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        last_d      = last_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = '0;
        ram_ren_d   = 1'b0;
        ram_wen_d   = 1'b0;
        rd1_vld_d   = 1'b0;
        rd1_id_d    = rd1_id_q;
        rd2_vld_d   = rd1_vld_q;
        rd2_id_d    = rd1_id_q;
        unique case (state_q)
            S_CLEAR: begin
                ram_wen_d   = 1'b1;
                ram_addr_d  = clr_addr_q;
                ram_wdata_d = '0;
                ram_be_d    = '1;
                clr_addr_d  = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (gnt_any) begin
                    last_d      = gnt_idx;
                    ram_addr_d  = addr_i[int'(gnt_idx)*ABITS +: ABITS];
                    ram_wdata_d = wdata_i[int'(gnt_idx)*DBITS +: DBITS];
                    if (we_i[gnt_idx]) begin
                        ram_wen_d = 1'b1;
                        ram_be_d  = be_i[int'(gnt_idx)*BE_W +: BE_W];
                    end else begin
                        ram_ren_d = 1'b1;
                        rd1_vld_d = 1'b1;
                        rd1_id_d  = gnt_idx;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (!RESET_N_i) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_addr_q  <= '0;
            last_q      <= IW'(NREQ - 1);
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            rd1_vld_q   <= 1'b0;
            rd1_id_q    <= '0;
            rd2_vld_q   <= 1'b0;
            rd2_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            last_q      <= last_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            rd1_vld_q   <= rd1_vld_d;
            rd1_id_q    <= rd1_id_d;
            rd2_vld_q   <= rd2_vld_d;
            rd2_id_q    <= rd2_id_d;
        end
    end

    assign gnt_o       = gnt;
    assign busy_o      = (state_q == S_CLEAR);
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_be_o    = ram_be_q;
    assign ram_ren_o   = ram_ren_q;
    assign ram_wen_o   = ram_wen_q;
    assign rvalid_o    = rd2_vld_q;
    assign rid_o       = rd2_id_q;
    assign rdata_o     = ram_rdata_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed stimulus, read returns checked
// against a queue of expected {id, data, cycle} entries.
module tb_bram_port_arbiter;

    localparam int NREQ  = 4;
    localparam int ABITS = 4;
    localparam int DBITS = 18;
    localparam int BE_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*ABITS-1:0] addr;
    logic [NREQ*DBITS-1:0] wdata;
    logic [NREQ*BE_W-1:0]  be;
    logic [NREQ-1:0]       gnt_o;
    logic                  rvalid_o;
    logic [1:0]            rid_o;
    logic [DBITS-1:0]      rdata_o;
    logic                  busy_o;
    logic [ABITS-1:0]      ram_addr_o;
    logic                  ram_ren_o;
    logic                  ram_wen_o;
    logic [BE_W-1:0]       ram_be_o;
    logic [DBITS-1:0]      ram_wdata_o;
    logic [DBITS-1:0]      ram_rdata;

    typedef struct {
        logic [1:0]  id;
        logic [17:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    bram_port_arbiter #(
        .NREQ(NREQ),
        .ABITS(ABITS),
        .DBITS(DBITS),
        .BE_W(BE_W),
        .CLEAR_ON_RESET(1)
    ) dut (
        .CLK_i(clk),
        .RESET_N_i(rst_n),
        .req_i(req),
        .we_i(we),
        .addr_i(addr),
        .wdata_i(wdata),
        .be_i(be),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rid_o(rid_o),
        .rdata_o(rdata_o),
        .busy_o(busy_o),
        .ram_addr_o(ram_addr_o),
        .ram_ren_o(ram_ren_o),
        .ram_wen_o(ram_wen_o),
        .ram_be_o(ram_be_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TDP36K x18 lanes: lane 0 = bits [7:0] + parity bit 16,
    // lane 1 = bits [15:8] + parity bit 17.
    logic [17:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 18'h3FFFF;
    end
    always @(posedge clk) begin
        if (ram_wen_o) begin
            if (ram_be_o[0]) begin
                mem[ram_addr_o][7:0] <= ram_wdata_o[7:0];
                mem[ram_addr_o][16]  <= ram_wdata_o[16];
            end
            if (ram_be_o[1]) begin
                mem[ram_addr_o][15:8] <= ram_wdata_o[15:8];
                mem[ram_addr_o][17]   <= ram_wdata_o[17];
            end
        end
        if (ram_ren_o) ram_rdata <= mem[ram_addr_o];
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rvalid_unexp: got rid %0d want none",
                         rid_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rid", 64'(rid_o), 64'(e.id));
                chk("rdata", 64'(rdata_o), 64'(e.data));
                chk("rlat", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic set_cmd(int k, logic w, logic [3:0] a,
                           logic [17:0] d, logic [1:0] b);
        we[k]            = w;
        addr[k*4 +: 4]   = a;
        wdata[k*18 +: 18] = d;
        be[k*2 +: 2]     = b;
    endtask

    task automatic grant_chk(logic [3:0] eg, logic [17:0] erd);
        chk("gnt", 64'(gnt_o), 64'(eg));
        for (int k = 0; k < NREQ; k++) begin
            if (eg[k] && !we[k]) begin
                sb.push_back('{id: 2'(k), data: erd, due: cyc + 2});
            end
        end
    endtask

    task automatic step(logic [3:0] eg, logic [17:0] erd);
        @(negedge clk);
        grant_chk(eg, erd);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_check();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_busy", 64'(busy_o), 64'd1);
            chk("clr_gnt", 64'(gnt_o), 64'd0);
            if (i > 0) begin
                chk("clr_wr",
                    64'({ram_wen_o, ram_ren_o, ram_addr_o,
                         ram_wdata_o, ram_be_o}),
                    64'({1'b1, 1'b0, 4'(i - 1), 18'h0, 2'b11}));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("clr_end", 64'({busy_o, ram_wen_o, ram_addr_o}),
            64'({1'b0, 1'b1, 4'hF}));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: no finish within time bound");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        for (int k = 0; k < NREQ; k++) begin
            set_cmd(k, 1'b0, 4'(5 + k), 18'h0, 2'b00);
        end
        req = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vals",
            64'({busy_o, gnt_o, ram_ren_o, ram_wen_o, ram_addr_o,
                 ram_wdata_o, ram_be_o, rvalid_o, rid_o}),
            64'h2_0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clear, then first grant to 0 as busy falls; round robin reads.
        clear_check();
        grant_chk(4'b0001, 18'h0);
        @(posedge clk);
        #1;
        step(4'b0010, 18'h0);
        step(4'b0100, 18'h0);
        step(4'b1000, 18'h0);
        step(4'b0001, 18'h0);
        step(4'b0010, 18'h0);

        // Write then read-back through a different requester.
        req = 4'b0100;
        set_cmd(2, 1'b1, 4'd9, 18'h2A5A5, 2'b11);
        step(4'b0100, 18'h0);
        req = 4'b0010;
        set_cmd(1, 1'b0, 4'd9, 18'h0, 2'b00);
        step(4'b0010, 18'h2A5A5);

        // Partial write on lane 0, then read.
        req = 4'b1000;
        set_cmd(3, 1'b1, 4'd9, 18'h00000, 2'b01);
        step(4'b1000, 18'h0);
        set_cmd(3, 1'b0, 4'd9, 18'h0, 2'b00);
        step(4'b1000, 18'h2A500);

        // Fairness between 0 and 3; idle cycles keep the pointer.
        req = 4'b1001;
        set_cmd(0, 1'b0, 4'd9, 18'h0, 2'b00);
        step(4'b0001, 18'h2A500);
        step(4'b1000, 18'h2A500);
        step(4'b0001, 18'h2A500);
        req = 4'b0000;
        step(4'b0000, 18'h0);
        step(4'b0000, 18'h0);
        step(4'b0000, 18'h0);
        req = 4'b1001;
        step(4'b1000, 18'h2A500);
        req = 4'b0000;
        step(4'b0000, 18'h0);

        // Reset one cycle after a read grant: that read never returns.
        req = 4'b1001;
        step(4'b0001, 18'h2A500);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("rst_vals2",
            64'({busy_o, gnt_o, ram_ren_o, ram_wen_o, ram_addr_o,
                 ram_wdata_o, ram_be_o, rvalid_o, rid_o}),
            64'h2_0000_0000);
        @(posedge clk);
        #1;
        req   = 4'b0000;
        rst_n = 1'b1;
        clear_check();
        chk("post_gnt", 64'(gnt_o), 64'd0);
        @(posedge clk);
        #1;
        step(4'b0000, 18'h0);
        step(4'b0000, 18'h0);
        step(4'b0000, 18'h0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
